// File: rtl/ika87ad_extbus_bridge.sv
// IKA87AD AD-bus to synchronous memory request/ack bridge.
// Optional core clock-enable stalling while memory is pending: define IKA87AD_EXTBUS_WAIT_EN.
module ika87ad_extbus_bridge #(
  parameter int RD_TIMEOUT = 15
) (
  input  logic        emuclk,
  input  logic        reset_n,
  input  logic        mcuclk_pcen,
  output logic        mcuclk_pcen_gated,
  input  logic        ale,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  addr_hi,
  input  logic [7:0]  pdo,
  output logic [7:0]  pdi,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err,
  output logic [2:0]  dbg_state
);

  // Memory handshake: mem_rd/mem_wr is the request, held high until the cycle
  // mem_ack is seen (mem_rdata valid in that cycle on reads) or the timeout fires.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_RDREQ  = 3'd2,
    S_RDHOLD = 3'd3,
    S_WRDATA = 3'd4,
    S_WRREQ  = 3'd5
  } state_t;

  state_t      state;
  logic        ale_q;
  logic        rd_q;
  logic        wr_q;
  logic [7:0]  addr_hi_q;
  logic [7:0]  pdo_q;
  logic [3:0]  cnt;

  logic ale_fall;
  logic ale_rise;
  logic rd_fall;
  logic rd_rise;
  logic wr_fall;
  logic wr_rise;
  logic both_low;
  logic in_cycle;
  logic cnt_done;

  assign ale_fall = ale_q & ~ale;
  assign ale_rise = ~ale_q & ale;
  assign rd_fall  = rd_q & ~rd_n;
  assign rd_rise  = ~rd_q & rd_n;
  assign wr_fall  = wr_q & ~wr_n;
  assign wr_rise  = ~wr_q & wr_n;
  assign both_low = ~rd_n & ~wr_n;
  assign in_cycle = (state != S_IDLE) && (state != S_ADDR);
  assign cnt_done = (cnt == 4'(RD_TIMEOUT));

  assign dbg_state = state;

`ifdef IKA87AD_EXTBUS_WAIT_EN
  assign mcuclk_pcen_gated = mcuclk_pcen & ~((state == S_RDREQ) | (state == S_WRREQ));
`else
  assign mcuclk_pcen_gated = mcuclk_pcen;
`endif

  always_ff @(posedge emuclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ale_q     <= 1'b0;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      addr_hi_q <= 8'h00;
      pdo_q     <= 8'h00;
      cnt       <= 4'd0;
      pdi       <= 8'hFF;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      ale_q     <= ale;
      rd_q      <= rd_n;
      wr_q      <= wr_n;
      addr_hi_q <= addr_hi;
      pdo_q     <= pdo;

      // Address is taken from the cycle before the fall, when the core still drives it.
      if (ale_fall) mem_addr <= {addr_hi_q, pdo_q};

      if (both_low) begin
        bus_err <= 1'b1;
      end else if (ale_rise && in_cycle) begin
        bus_err <= 1'b1;
        mem_rd  <= 1'b0;
        mem_wr  <= 1'b0;
        pdi     <= 8'hFF;
        cnt     <= 4'd0;
        state   <= S_ADDR;
      end else begin
        case (state)
          S_IDLE: begin
            if (ale_fall) state <= S_ADDR;
          end
          S_ADDR: begin
            if (rd_fall) begin
              mem_rd <= 1'b1;
              cnt    <= 4'd0;
              state  <= S_RDREQ;
            end else if (wr_fall) begin
              mem_wdata <= pdo;
              state     <= S_WRDATA;
            end
          end
          S_RDREQ: begin
            if (mem_ack) begin
              pdi    <= mem_rdata;
              mem_rd <= 1'b0;
              state  <= S_RDHOLD;
            end else if (rd_rise) begin
              bus_err <= 1'b1;
              mem_rd  <= 1'b0;
              state   <= S_IDLE;
            end else if (cnt_done) begin
              bus_err <= 1'b1;
              pdi     <= 8'hFF;
              mem_rd  <= 1'b0;
              state   <= S_RDHOLD;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          S_RDHOLD: begin
            if (rd_rise) begin
              pdi   <= 8'hFF;
              state <= S_IDLE;
            end
          end
          S_WRDATA: begin
            if (!wr_n) mem_wdata <= pdo;
            if (wr_rise) begin
              mem_wr <= 1'b1;
              cnt    <= 4'd0;
              state  <= S_WRREQ;
            end
          end
          S_WRREQ: begin
            if (mem_ack) begin
              mem_wr <= 1'b0;
              state  <= S_IDLE;
            end else if (cnt_done) begin
              bus_err <= 1'b1;
              mem_wr  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            pdi    <= 8'hFF;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ika87ad_extbus_bridge.sv
// Self-checking bench for ika87ad_extbus_bridge: a bus-cycle driver, a memory responder,
// and a transaction-level model of what each core read/write must produce.
module tb_ika87ad_extbus_bridge;

`ifdef IKA87AD_EXTBUS_WAIT_EN
  localparam bit WAIT_MODE = 1'b1;
`else
  localparam bit WAIT_MODE = 1'b0;
`endif
  localparam int MAX_LAT = 15;

  logic        emuclk = 1'b0;
  logic        reset_n;
  logic        mcuclk_pcen;
  logic        mcuclk_pcen_gated;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  addr_hi;
  logic [7:0]  pdo;
  logic [7:0]  pdi;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        bus_err;
  logic [2:0]  dbg_state;

  ika87ad_extbus_bridge dut (
    .emuclk            (emuclk),
    .reset_n           (reset_n),
    .mcuclk_pcen       (mcuclk_pcen),
    .mcuclk_pcen_gated (mcuclk_pcen_gated),
    .ale               (ale),
    .rd_n              (rd_n),
    .wr_n              (wr_n),
    .addr_hi           (addr_hi),
    .pdo               (pdo),
    .pdi               (pdi),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rd            (mem_rd),
    .mem_wr            (mem_wr),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .bus_err           (bus_err),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 emuclk = ~emuclk;

  // scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic        exp_err;
  logic [7:0]  ref_mem [logic [15:0]];
  logic [7:0]  bus_mem [logic [15:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_get(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'hFF;
  endfunction

  function automatic logic [7:0] bus_get(input logic [15:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'hFF;
  endfunction

  // driver tasks
  task automatic addr_phase(input logic [15:0] a);
    @(negedge emuclk);
    ale = 1'b1; addr_hi = a[15:8]; pdo = a[7:0];
    @(negedge emuclk);
    @(negedge emuclk);
    ale = 1'b0;
    @(negedge emuclk);
    check("mem_addr", mem_addr, a);
  endtask

  // Memory responder: acks the lat-th cycle of a pending request; returns the number of
  // cycles the request was seen high and how many of them had the core enable held low.
  task automatic mem_cycle(input bit is_rd, input int lat, input logic [7:0] wexp,
                           output int hi, output int lowpc);
    bit seen;
    seen = 1'b0; hi = 0; lowpc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge emuclk);
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (!mcuclk_pcen_gated) lowpc++;
      if (is_rd ? mem_rd : mem_wr) begin
        seen = 1'b1;
        if (!is_rd && hi == 0) check("mem_wdata", mem_wdata, wexp);
        if (hi == lat) begin
          mem_ack = 1'b1;
          if (is_rd) mem_rdata = bus_get(mem_addr);
          else bus_mem[mem_addr] = mem_wdata;
        end
        hi++;
      end else if (seen) begin
        break;
      end
    end
    check(is_rd ? "rd_req_done" : "wr_req_done", {31'd0, seen && !(is_rd ? mem_rd : mem_wr)}, 32'd1);
  endtask

  task automatic do_read(input logic [15:0] a, input int lat);
    int hi, lowpc, exp_hi;
    logic [7:0] exp_pdi;
    addr_phase(a);
    exp_hi  = (lat <= MAX_LAT) ? lat + 1 : MAX_LAT + 1;
    exp_pdi = (lat <= MAX_LAT) ? ref_get(a) : 8'hFF;
    if (lat > MAX_LAT) exp_err = 1'b1;
    exp_q.push_back(exp_pdi);
    pdo = 8'($urandom); rd_n = 1'b0;
    mem_cycle(1'b1, lat, 8'h00, hi, lowpc);
    check("rd_cycles", hi, exp_hi);
    check("rd_pcen_low", lowpc, WAIT_MODE ? exp_hi : 0);
    check("pdi_hold", pdi, exp_q.pop_front());
    @(negedge emuclk);
    check("pdi_hold2", pdi, exp_pdi);
    rd_n = 1'b1;
    @(negedge emuclk);
    check("pdi_idle", pdi, 8'hFF);
    check("bus_err_rd", bus_err, exp_err);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int lat);
    int hi, lowpc;
    addr_phase(a);
    pdo = 8'($urandom); wr_n = 1'b0;
    @(negedge emuclk);
    pdo = d;
    @(negedge emuclk);
    @(negedge emuclk);
    wr_n = 1'b1; pdo = ~d;
    mem_cycle(1'b0, lat, d, hi, lowpc);
    ref_mem[a] = d;
    check("wr_cycles", hi, lat + 1);
    check("wr_pcen_low", lowpc, WAIT_MODE ? lat + 1 : 0);
    check("bus_err_wr", bus_err, exp_err);
  endtask

  task automatic do_reset();
    @(negedge emuclk);
    reset_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; ale = 1'b0; mem_ack = 1'b0;
    exp_err = 1'b0;
    @(negedge emuclk);
    reset_n = 1'b1;
    @(negedge emuclk);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    reset_n = 1'b0; mcuclk_pcen = 1'b1; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    addr_hi = 8'h00; pdo = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00; exp_err = 1'b0;
    for (int h = 0; h < 4; h++)
      for (int l = 0; l < 4; l++) begin
        d = 8'($urandom);
        ref_mem[{8'(8'h40 + h), 8'(8'h80 + l)}] = d;
        bus_mem[{8'(8'h40 + h), 8'(8'h80 + l)}] = d;
      end
    ref_mem[16'h1234] = 8'hA5;
    bus_mem[16'h1234] = 8'hA5;

    repeat (3) @(negedge emuclk);
    check("rst_pdi", pdi, 8'hFF);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_wdata", mem_wdata, 8'h00);
    check("rst_req", {mem_rd, mem_wr}, 2'b00);
    check("rst_err", bus_err, 1'b0);
    check("rst_pcen", mcuclk_pcen_gated, mcuclk_pcen);
    reset_n = 1'b1;
    @(negedge emuclk);

    // basic read and write
    do_read(16'h1234, 2);
    do_write(16'hFF00, 8'h5A, 3);
    check("wr_ff00", bus_get(16'hFF00), 8'h5A);

    // random traffic, all acks inside the timeout window
    for (int t = 0; t < 30; t++) begin
      a = {8'(8'h40 + $urandom_range(0, 3)), 8'(8'h80 + $urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) do_read(a, $urandom_range(0, MAX_LAT));
      else do_write(a, 8'($urandom), $urandom_range(0, 12));
    end

    // timeout: no ack at all
    do_read(16'h4081, 100);
    do_read(16'h4182, 1);

    // RD_n released before the memory answers
    do_reset();
    addr_phase(16'h4283);
    rd_n = 1'b0;
    repeat (3) @(negedge emuclk);
    check("early_rd_pending", mem_rd, 1'b1);
    rd_n = 1'b1;
    @(negedge emuclk);
    check("early_rd_err", bus_err, 1'b1);
    check("early_rd_drop", mem_rd, 1'b0);
    check("early_rd_pdi", pdi, 8'hFF);
    check("early_rd_pcen", mcuclk_pcen_gated, mcuclk_pcen);

    // reset while a read is pending; a late ack must be ignored
    addr_phase(16'h4380);
    rd_n = 1'b0;
    repeat (3) @(negedge emuclk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rd", mem_rd, 1'b0);
    check("mid_rst_pdi", pdi, 8'hFF);
    check("mid_rst_addr", mem_addr, 16'h0000);
    check("mid_rst_err", bus_err, 1'b0);
    rd_n = 1'b1; exp_err = 1'b0;
    @(negedge emuclk);
    reset_n = 1'b1;
    @(negedge emuclk);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    @(negedge emuclk);
    mem_ack = 1'b0;
    @(negedge emuclk);
    check("late_ack_req", {mem_rd, mem_wr}, 2'b00);
    check("late_ack_pdi", pdi, 8'hFF);
    check("late_ack_err", bus_err, 1'b0);

    // ALE rise while a read is pending
    addr_phase(16'h4081);
    rd_n = 1'b0;
    repeat (2) @(negedge emuclk);
    ale = 1'b1;
    @(negedge emuclk);
    check("ale_abort_err", bus_err, 1'b1);
    check("ale_abort_rd", mem_rd, 1'b0);
    exp_err = 1'b1;
    rd_n = 1'b1;
    do_read(16'h4182, 4);

    // RD_n and WR_n low together
    do_reset();
    addr_phase(16'h4383);
    rd_n = 1'b0; wr_n = 1'b0;
    @(negedge emuclk);
    check("both_low_err", bus_err, 1'b1);
    check("both_low_req", {mem_rd, mem_wr}, 2'b00);
    exp_err = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1;
    @(negedge emuclk);
    do_read(16'h4383, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
